// File: rtl/operand_frame_sequencer.sv
// operand_frame_sequencer: frames A/B beats from a shared bus into an external adder and hands off the registered result
module operand_frame_sequencer #(
    parameter int WIDTH = 7,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     ab_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     op_a,
    output logic [WIDTH-1:0]     op_b,
    input  logic [WIDTH-1:0]     sum_in,
    input  logic                 carry_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_sum,
    output logic                 res_carry,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] done_count
);
    typedef enum logic [1:0] {S_A, S_B, S_ADD, S_OUT} state_t;
    state_t state, state_nx;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_A;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        in_ready = state == S_A || state == S_B;
        res_valid = state == S_OUT;
        busy = state != S_A;
        state_nx = state == S_A   ? (in_valid  ? S_B   : S_A) :
                   state == S_B   ? (in_valid  ? S_ADD : S_B) :
                   state == S_ADD ? S_OUT :
                                    (res_ready ? S_A   : S_OUT);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            res_sum    <= '0;
            res_carry  <= 1'b0;
            done_count <= '0;
        end else begin
            if (state == S_A && in_valid) op_a <= ab_in;
            if (state == S_B && in_valid) op_b <= ab_in;
            if (state == S_ADD) begin
                res_sum   <= sum_in;
                res_carry <= carry_in;
            end
            if (state == S_OUT && res_ready) done_count <= done_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_operand_frame_sequencer.sv
// tb_operand_frame_sequencer: randomized frames checked against an arithmetic reference model
module tb_operand_frame_sequencer;
    localparam int WIDTH = 7;
    localparam int CNT_WIDTH = 8;
    logic clk = 1'b0;
    logic rst_n;
    logic [WIDTH-1:0] ab_in;
    logic in_valid;
    logic in_ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] sum_in;
    logic carry_in;
    logic res_valid;
    logic res_ready;
    logic [WIDTH-1:0] res_sum;
    logic res_carry;
    logic busy;
    logic [CNT_WIDTH-1:0] done_count;
    int chk = 0;
    int err = 0;
    int accepted = 0;

    always #5 clk = ~clk;

    // stand-in for the external carry look-ahead adder
    assign {carry_in, sum_in} = {1'b0, op_a} + {1'b0, op_b};

    operand_frame_sequencer #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .ab_in(ab_in), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sum_in(sum_in), .carry_in(carry_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum), .res_carry(res_carry),
        .busy(busy), .done_count(done_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_frame(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input int gap, input int hold, input bit accept);
        logic [WIDTH:0] want;
        want = {1'b0, a} + {1'b0, b};
        chk++; if (in_ready !== 1'b1 || busy !== 1'b0) begin err++; $display("FAIL idle_state: in_ready=%b busy=%b required 1/0", in_ready, busy); end
        in_valid = 1'b1;
        ab_in = a;
        tick();
        in_valid = 1'b0;
        ab_in = WIDTH'($urandom);
        chk++; if (op_a !== a || busy !== 1'b1 || in_ready !== 1'b1) begin err++; $display("FAIL a_capture: op_a=%h busy=%b in_ready=%b required %h/1/1", op_a, busy, in_ready, a); end
        repeat (gap) tick();
        chk++; if (op_a !== a || in_ready !== 1'b1 || res_valid !== 1'b0) begin err++; $display("FAIL wait_b: op_a=%h in_ready=%b res_valid=%b required %h/1/0", op_a, in_ready, res_valid, a); end
        in_valid = 1'b1;
        ab_in = b;
        tick();
        in_valid = 1'b0;
        ab_in = WIDTH'($urandom);
        chk++; if (op_b !== b || op_a !== a || in_ready !== 1'b0 || res_valid !== 1'b0) begin err++; $display("FAIL settle: op_b=%h op_a=%h in_ready=%b res_valid=%b required %h/%h/0/0", op_b, op_a, in_ready, res_valid, b, a); end
        tick();
        chk++; if (res_valid !== 1'b1 || {res_carry, res_sum} !== want || in_ready !== 1'b0) begin err++; $display("FAIL result: valid=%b carry,sum=%h in_ready=%b required 1/%h/0", res_valid, {res_carry, res_sum}, in_ready, want); end
        repeat (hold) tick();
        chk++; if (res_valid !== 1'b1 || {res_carry, res_sum} !== want) begin err++; $display("FAIL result_hold: valid=%b carry,sum=%h required 1/%h", res_valid, {res_carry, res_sum}, want); end
        if (accept) begin
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            accepted++;
            chk++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done_count !== CNT_WIDTH'(accepted)) begin err++; $display("FAIL accept: valid=%b in_ready=%b busy=%b count=%0d required 0/1/0/%0d", res_valid, in_ready, busy, done_count, CNT_WIDTH'(accepted)); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        res_ready = 1'b0;
        ab_in = '0;
        #3;
        chk++; if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || op_a !== 0 || op_b !== 0 || res_sum !== 0 || res_carry !== 1'b0 || done_count !== 0) begin err++; $display("FAIL reset_outputs: ready=%b busy=%b valid=%b a=%h b=%h sum=%h c=%b cnt=%0d", in_ready, busy, res_valid, op_a, op_b, res_sum, res_carry, done_count); end
        tick();
        rst_n = 1'b1;
        tick();
        chk++; if (in_ready !== 1'b1 || busy !== 1'b0 || done_count !== 0) begin err++; $display("FAIL post_reset: ready=%b busy=%b cnt=%0d required 1/0/0", in_ready, busy, done_count); end
        accepted = 0;
    endtask

    task automatic test_basic();
        do_frame(7'h05, 7'h03, 0, 0, 1'b1);
    endtask

    task automatic test_carry();
        do_frame(7'h7F, 7'h01, 0, 0, 1'b1);
        do_frame(7'h7F, 7'h7F, 0, 0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a, b;
        logic [WIDTH:0] want;
        a = 7'h2A;
        b = 7'h33;
        want = {1'b0, a} + {1'b0, b};
        do_frame(a, b, 0, 0, 1'b0);
        in_valid = 1'b1;
        ab_in = 7'h11;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk++; if (in_ready !== 1'b0 || res_valid !== 1'b1 || {res_carry, res_sum} !== want || op_a !== a) begin err++; $display("FAIL backpressure_%0d: ready=%b valid=%b carry,sum=%h op_a=%h required 0/1/%h/%h", i, in_ready, res_valid, {res_carry, res_sum}, op_a, want, a); end
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        accepted++;
        chk++; if (res_valid !== 1'b0 || in_ready !== 1'b1 || op_a !== a || done_count !== CNT_WIDTH'(accepted)) begin err++; $display("FAIL bp_release: valid=%b ready=%b op_a=%h cnt=%0d required 0/1/%h/%0d", res_valid, in_ready, op_a, done_count, a, CNT_WIDTH'(accepted)); end
        do_frame(7'h11, 7'h22, 0, 0, 1'b1);
    endtask

    task automatic test_gaps();
        for (int i = 0; i < 8; i++)
            do_frame(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(1, 5)), int'($urandom_range(0, 3)), 1'b1);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        ab_in = 7'h55;
        tick();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk++; if (busy !== 1'b0 || in_ready !== 1'b1 || op_a !== 0 || done_count !== 0) begin err++; $display("FAIL reset_in_b: busy=%b ready=%b op_a=%h cnt=%0d required 0/1/0/0", busy, in_ready, op_a, done_count); end
        rst_n = 1'b1;
        accepted = 0;
        tick();
        do_frame(7'h66, 7'h44, 0, 0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk++; if (res_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || res_sum !== 0 || res_carry !== 1'b0 || op_a !== 0 || op_b !== 0 || done_count !== 0) begin err++; $display("FAIL reset_in_out: valid=%b busy=%b ready=%b sum=%h c=%b a=%h b=%h cnt=%0d", res_valid, busy, in_ready, res_sum, res_carry, op_a, op_b, done_count); end
        rst_n = 1'b1;
        tick();
        do_frame(7'h02, 7'h02, 0, 0, 1'b1);
    endtask

    task automatic test_wrap();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        accepted = 0;
        tick();
        for (int i = 0; i < 256; i++)
            do_frame(WIDTH'($urandom), WIDTH'($urandom), 0, 0, 1'b1);
        chk++; if (done_count !== 0) begin err++; $display("FAIL count_wrap: cnt=%0d required 0", done_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", chk, err);
        $finish;
    end
endmodule

// File: doc/operand_frame_sequencer.md
Name: operand_frame_sequencer

Overview:
- Host-side companion to the carry look-ahead adder.
- The chip shares one WIDTH-bit data bus between both operands. This block receives operand A, then operand B, over that bus with a valid/ready handshake.
- It presents both operands as stable registers to the combinational adder, samples the sum and carry after one settle cycle, and holds the result for the output side until it is accepted.
- It supplies the framing, operand storage and result handoff that the bare adder lacks.

Parameters:
- WIDTH, 7, operand and result width in bits.
- CNT_WIDTH, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ab_in  input  WIDTH  shared operand bus: A on the first beat, B on the second.
- in_valid  input  1  ab_in carries a valid beat.
- in_ready  output  1  block can accept a beat this cycle.
- op_a  output  WIDTH  registered operand A, to the adder a input.
- op_b  output  WIDTH  registered operand B, to the adder b input.
- sum_in  input  WIDTH  adder sum output s.
- carry_in  input  1  adder carry output c.
- res_valid  output  1  result held and valid.
- res_ready  input  1  consumer accepts the result.
- res_sum  output  WIDTH  registered sum.
- res_carry  output  1  registered carry.
- busy  output  1  high in any state other than S_A.
- done_count  output  CNT_WIDTH  number of results accepted by the consumer.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to S_A.
  - op_a, op_b, res_sum, res_carry and done_count go to 0.
  - res_valid goes to 0, busy to 0, in_ready to 1.
  - Reset takes effect immediately. Any partial frame or pending result is discarded; nothing is counted.
- An input beat transfers on a rising edge where in_valid && in_ready.
- A result transfers on a rising edge where res_valid && res_ready.
- State S_A:
  - in_ready=1.
  - On a beat: op_a<=ab_in, go to S_B.
  - Without a beat: stay in S_A.
- State S_B:
  - in_ready=1.
  - On a beat: op_b<=ab_in, go to S_ADD.
  - Without a beat: stay in S_B, op_a held. There is no timeout.
- State S_ADD:
  - in_ready=0.
  - One settle cycle: the adder sees stable op_a/op_b for a full cycle.
  - At the end of the cycle: res_sum<=sum_in, res_carry<=carry_in, go to S_OUT.
- State S_OUT:
  - in_ready=0, res_valid=1.
  - res_sum/res_carry are held stable until the transfer.
  - On transfer: done_count<=done_count+1 (wraps modulo 2^CNT_WIDTH), go to S_A.
  - Without transfer: stay in S_OUT indefinitely.
- Outputs:
  - in_ready, res_valid and busy are decoded from state only; there is no combinational path from inputs to outputs.
  - op_a and op_b hold their last values in all states and change only on accepted beats.
- Latency:
  - A accepted at edge N, B accepted at edge N+1.
  - Result captured at edge N+2; res_valid is high after edge N+2.
  - With res_ready held high, the result transfers at edge N+3 and the block is back in S_A, ready for a new A.
  - Minimum frame period: 4 cycles.
- Beats offered while in_ready=0 are ignored. The driver must hold in_valid and ab_in until the transfer.
- A simultaneous in_valid and res_ready in S_OUT accepts only the result. The input beat is taken in S_A on the following cycle.
- Arithmetic: the result is the adder's WIDTH-bit sum plus a carry out. The adder's result is stored exactly as received; the block does no arithmetic of its own apart from the counter.
- Counter: done_count counts results accepted by the consumer. Reset is the only clear.

Test Plan:
- Basic add: A=7'h05, B=7'h03, res_ready=1 -> res_valid high for 1 cycle with res_sum=7'h08, res_carry=0 at the cycle after the S_ADD capture; done_count=1.
- Carry out: A=7'h7F, B=7'h01 -> res_sum=7'h00, res_carry=1. Then A=7'h7F, B=7'h7F -> res_sum=7'h7E, res_carry=1; done_count=2.
- Backpressure: res_ready=0 for 10 cycles after a result, with in_valid held high and ab_in=7'h11 -> in_ready=0 throughout, res_sum stable, op_a unchanged. On res_ready=1 the result transfers, and 7'h11 is taken as the next A one cycle later.
- Input gaps: in_valid toggled 0/1 with idle cycles between the A and B beats -> op_a captured once, the FSM waits in S_B, the result is correct, and latency from the B beat to res_valid is 1 cycle.
- Reset mid-frame: assert rst_n=0 asynchronously in S_B, then in S_OUT -> outputs clear immediately, done_count=0, state S_A. The next A=7'h02, B=7'h02 gives 7'h04.
- Counter wrap: 256 back-to-back frames at the 4-cycle rate -> done_count wraps to 0 on the 256th accept, and every result is correct against a reference model.
